// File: rtl/winograd_f23_engine.sv
// Winograd F(2,3) engine: four transform products on one serial radix-2 Booth multiplier.
// Define WINOGRAD_SAT_EN to clamp outputs to DW bits instead of wrapping.
module winograd_f23_engine #(
  parameter int DW   = 16,
  parameter int FRAC = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] d0,
  input  logic [DW-1:0] d1,
  input  logic [DW-1:0] d2,
  input  logic [DW-1:0] d3,
  input  logic [DW-1:0] g0,
  input  logic [DW-1:0] g1,
  input  logic [DW-1:0] g2,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] y0,
  output logic [DW-1:0] y1,
  output logic          busy
);
  localparam int MW = DW + 1;
  localparam int AW = DW + 2;
  localparam int PW = 2 * DW + 2;
  localparam int SW = 2 * DW + 4;
  localparam int CW = $clog2(DW + 2);

  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, OUT = 2'd2} state_t;

  state_t               state_q, state_d;
  logic                 rdy_q;
  logic [3:0][DW-1:0]   d_q, d_d;
  logic [2:0][DW-1:0]   g_q, g_d;
  logic [1:0]           idx_q, idx_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic signed [AW-1:0] acc_q, acc_d;
  logic [MW-1:0]        mq_q, mq_d;
  logic                 qm1_q, qm1_d;
  logic [3:0][PW-1:0]   t_q, t_d;
  logic [DW-1:0]        y0_q, y0_d, y1_q, y1_d;
  logic                 ovld_q, ovld_d;

  logic signed [MW-1:0] m [4];
  logic signed [MW-1:0] k [4];
  logic signed [AW-1:0] gs1, gs2;

  always_comb begin
    m[0] = MW'($signed(d_q[0])) - MW'($signed(d_q[2]));
    m[1] = MW'($signed(d_q[1])) + MW'($signed(d_q[2]));
    m[2] = MW'($signed(d_q[2])) - MW'($signed(d_q[1]));
    m[3] = MW'($signed(d_q[1])) - MW'($signed(d_q[3]));
    gs1  = AW'($signed(g_q[0])) + AW'($signed(g_q[1])) + AW'($signed(g_q[2]));
    gs2  = AW'($signed(g_q[0])) - AW'($signed(g_q[1])) + AW'($signed(g_q[2]));
    k[0] = MW'($signed(g_q[0]));
    k[1] = MW'(gs1 >>> 1);
    k[2] = MW'(gs2 >>> 1);
    k[3] = MW'($signed(g_q[2]));
  end

  // One Booth step per cycle; cnt==0 starts a fresh product from the selected operands.
  logic                 first, qm_cur;
  logic signed [AW-1:0] a_cur, a_add, a_nxt, k_ext;
  logic [MW-1:0]        q_cur, q_nxt;
  logic signed [PW-1:0] prod;

  always_comb begin
    first  = (cnt_q == '0);
    a_cur  = first ? '0 : acc_q;
    q_cur  = first ? m[idx_q] : mq_q;
    qm_cur = first ? 1'b0 : qm1_q;
    k_ext  = AW'(k[idx_q]);
    case ({q_cur[0], qm_cur})
      2'b01:   a_add = a_cur + k_ext;
      2'b10:   a_add = a_cur - k_ext;
      default: a_add = a_cur;
    endcase
    a_nxt = {a_add[AW-1], a_add[AW-1:1]};
    q_nxt = {a_add[0], q_cur[MW-1:1]};
    prod  = PW'({a_nxt, q_nxt});
  end

  logic signed [SW-1:0] s0, s1;
  always_comb begin
    s0 = SW'($signed(t_q[0])) + SW'($signed(t_q[1])) + SW'($signed(t_q[2]));
    s1 = SW'($signed(t_q[1])) - SW'($signed(t_q[2])) - SW'($signed(t_q[3]));
  end

`ifdef WINOGRAD_SAT_EN
  localparam logic signed [SW-1:0] YMAX = SW'((64'sd1 <<< (DW - 1)) - 64'sd1);
  localparam logic signed [SW-1:0] YMIN = ~YMAX;

  function automatic logic [DW-1:0] reduce(input logic signed [SW-1:0] s);
    logic signed [SW-1:0] sh;
    sh = s >>> FRAC;
    if (sh > YMAX) return DW'(YMAX);
    if (sh < YMIN) return DW'(YMIN);
    return DW'(sh);
  endfunction
`else
  function automatic logic [DW-1:0] reduce(input logic signed [SW-1:0] s);
    return DW'(s >>> FRAC);
  endfunction
`endif

  always_comb begin
    state_d = state_q;
    d_d     = d_q;
    g_d     = g_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mq_d    = mq_q;
    qm1_d   = qm1_q;
    t_d     = t_q;
    y0_d    = y0_q;
    y1_d    = y1_q;
    ovld_d  = ovld_q;
    case (state_q)
      IDLE: if (in_valid && rdy_q) begin
        d_d     = {d3, d2, d1, d0};
        g_d     = {g2, g1, g0};
        idx_d   = '0;
        cnt_d   = '0;
        state_d = MUL;
      end
      MUL: begin
        // cnt == DW+1 only after t3 is stored: spend that cycle reducing the sums.
        if (cnt_q != CW'(DW + 1)) begin
          acc_d = a_nxt;
          mq_d  = q_nxt;
          qm1_d = q_cur[0];
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(DW)) begin
            t_d[idx_q] = prod;
            if (idx_q != 2'd3) begin
              idx_d = idx_q + 1'b1;
              cnt_d = '0;
            end
          end
        end else begin
          y0_d    = reduce(s0);
          y1_d    = reduce(s1);
          ovld_d  = 1'b1;
          state_d = OUT;
        end
      end
      OUT: if (out_ready) begin
        ovld_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rdy_q   <= 1'b0;
      d_q     <= '0;
      g_q     <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      mq_q    <= '0;
      qm1_q   <= 1'b0;
      t_q     <= '0;
      y0_q    <= '0;
      y1_q    <= '0;
      ovld_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rdy_q   <= 1'b1;
      d_q     <= d_d;
      g_q     <= g_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mq_q    <= mq_d;
      qm1_q   <= qm1_d;
      t_q     <= t_d;
      y0_q    <= y0_d;
      y1_q    <= y1_d;
      ovld_q  <= ovld_d;
    end
  end

  assign in_ready  = rdy_q && (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = ovld_q;
  assign y0        = y0_q;
  assign y1        = y1_q;
endmodule
